// File: rtl/rf_config_sequencer.sv
// Power-up sequencer for an RF transceiver: pulses the chip reset, waits for it to
// settle, then streams NUM_CMDS register writes from a command ROM through an SPI master.
module rf_config_sequencer #(
  parameter int RESET_CYCLES = 2000,
  parameter int READY_WAIT   = 200,
  parameter int NUM_CMDS     = 368,
  parameter int GAP_CYCLES   = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [8:0]  rom_addr,
  input  logic [23:0] rom_data,
  output logic        spi_start,
  output logic [23:0] spi_word,
  input  logic        spi_busy,
  input  logic        spi_done,
  output logic        rf_xreset_n,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  cmd_count
);

  localparam int MAX_A = (RESET_CYCLES > READY_WAIT) ? RESET_CYCLES : READY_WAIT;
  localparam int MAX_B = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] RDY_LAST = CW'(READY_WAIT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [3:0] {
    IDLE, HOLD_RST, WAIT_RDY, FETCH, LOAD, ISSUE, WAIT_SPI, GAP, FINISH, ERROR
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          launch;
  logic          run_req;
  logic [8:0]    cmd_nxt;
  logic          last_done, last_gap;

  assign run_req   = start && (state == IDLE || state == FINISH || state == ERROR);
  assign cmd_nxt   = cmd_count + 9'd1;
  assign last_done = (cmd_nxt == 9'(NUM_CMDS));
  assign last_gap  = (cmd_count == 9'(NUM_CMDS));

  // One shared dwell counter: cleared on every state change, saturates so a
  // long stall in ISSUE can never wrap it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE, FINISH, ERROR: if (start) state_nxt = HOLD_RST;
      HOLD_RST: if (cnt == RST_LAST) state_nxt = WAIT_RDY;
      WAIT_RDY: if (cnt == RDY_LAST) state_nxt = FETCH;
      FETCH:    state_nxt = LOAD;
      LOAD:     state_nxt = ISSUE;
      ISSUE: begin
        if (!spi_busy) begin
          launch    = 1'b1;
          state_nxt = WAIT_SPI;
        end
      end
      WAIT_SPI: begin
        // A completion on the final timeout clock still counts as success.
        if (spi_done) begin
          if (GAP_CYCLES > 0) state_nxt = GAP;
          else                state_nxt = last_done ? FINISH : FETCH;
        end else if (cnt == TO_LAST) begin
          state_nxt = ERROR;
        end
      end
      GAP:      if (cnt == GAP_LAST) state_nxt = last_gap ? FINISH : FETCH;
      default:  state_nxt = IDLE;
    endcase
  end

  assign spi_start   = launch;
  assign busy        = !(state == IDLE || state == FINISH || state == ERROR);
  // Chip stays in reset from power-on until the first run is requested.
  assign rf_xreset_n = !(state == IDLE || state == HOLD_RST);

  // rom_addr tracks cmd_count, so the ROM word is already settled when FETCH begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done      <= 1'b0;
      err       <= 1'b0;
      cmd_count <= '0;
      rom_addr  <= '0;
      spi_word  <= '0;
    end else begin
      if (run_req) begin
        done      <= 1'b0;
        err       <= 1'b0;
        cmd_count <= '0;
        rom_addr  <= '0;
      end
      if (state == LOAD) spi_word <= rom_data;
      if (state == WAIT_SPI && spi_done) begin
        cmd_count <= cmd_nxt;
        rom_addr  <= cmd_nxt;
      end
      if (state_nxt == FINISH) done <= 1'b1;
      if (state_nxt == ERROR)  err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_config_sequencer.sv
// Bench for rf_config_sequencer: ROM + SPI slave models, spi_word scoreboard,
// sequence timing checks, start-ignore, busy stall, mid-run reset and timeout.
module tb_rf_config_sequencer;
  localparam int RST_C     = 20;
  localparam int RDY_C     = 5;
  localparam int N_CMD     = 4;
  localparam int GAP_C     = 2;
  localparam int TO_C      = 16;
  localparam int SPI_LAT   = 10;
  localparam int CMD_LEN   = 3 + SPI_LAT + GAP_C;          // FETCH, LOAD, ISSUE, wait, gap
  localparam int START_OFF = RST_C + RDY_C + 2;            // first busy cycle -> first spi_start
  localparam int DONE_OFF  = RST_C + RDY_C + N_CMD * CMD_LEN;

  logic        clk = 0, reset = 0, start = 0;
  logic [8:0]  rom_addr, cmd_count;
  logic [23:0] rom_data = '0, spi_word;
  logic        spi_start, spi_busy, spi_done = 0;
  logic        rf_xreset_n, busy, done, err;

  always #5 clk = ~clk;

  rf_config_sequencer #(
    .RESET_CYCLES(RST_C), .READY_WAIT(RDY_C), .NUM_CMDS(N_CMD),
    .GAP_CYCLES(GAP_C), .TIMEOUT(TO_C)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .spi_start(spi_start), .spi_word(spi_word),
    .spi_busy(spi_busy), .spi_done(spi_done),
    .rf_xreset_n(rf_xreset_n), .busy(busy), .done(done), .err(err),
    .cmd_count(cmd_count)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [23:0] rom [N_CMD] = '{24'h1234a5, 24'h007f3c, 24'hbeef01, 24'h8000ff};
  always @(posedge clk) rom_data <= (rom_addr < N_CMD) ? rom[rom_addr[1:0]] : 24'h0;

  // SPI slave: done pulse SPI_LAT clocks after the start pulse, busy meanwhile.
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic m_act = 0;
  int   m_rem = 0, m_idx = 0, drop_idx = -1, hb_from = -1, hb_len = 0;
  assign spi_busy = m_act || (cyc >= hb_from && cyc < hb_from + hb_len);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_act <= 0; m_rem <= 0; m_idx <= 0; spi_done <= 0;
    end else begin
      spi_done <= 1'b0;
      if (start) m_idx <= 0;
      if (spi_start) begin
        m_act <= 1'b1;
        m_rem <= (m_idx == drop_idx) ? -1 : SPI_LAT;
        m_idx <= m_idx + 1;
      end else if (m_act && m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 2) begin
          spi_done <= 1'b1;
          m_act    <= 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard on spi_start, event timestamps for timing checks.
  logic [23:0] exp_q[$];
  logic [23:0] held_word = '0;
  int   n_starts = 0, first_start = -1, last_start = -1;
  int   busy_rise = -1, done_rise = -1, err_rise = -1, low_cnt = 0;
  logic prev_start = 0, prev_busy = 0, prev_done = 0, prev_err = 0;

  always @(negedge clk) begin
    if (spi_start) begin
      if (exp_q.size() == 0) chk("spi_start_extra", spi_start, 1'b0);
      else                   chk("spi_word", spi_word, exp_q.pop_front());
      chk("spi_start_b2b", prev_start, 1'b0);
      if (n_starts == 0) first_start = cyc;
      last_start = cyc;
      n_starts++;
      held_word = spi_word;
    end
    if (spi_done && !reset) chk("spi_word_hold", spi_word, held_word);
    if (busy && !prev_busy) busy_rise = cyc;
    if (done && !prev_done) done_rise = cyc;
    if (err && !prev_err)   err_rise  = cyc;
    if (busy && !rf_xreset_n) low_cnt++;
    prev_start = spi_start; prev_busy = busy; prev_done = done; prev_err = err;
  end

  task automatic pulse_start();
    n_starts = 0; low_cnt = 0; busy_rise = -1; done_rise = -1; first_start = -1; err_rise = -1;
    for (int i = 0; i < N_CMD; i++) exp_q.push_back(rom[i]);
    @(negedge clk); start = 1;
  endtask

  task automatic run_seq(input string tag, input bit inject, input int hold);
    int  c0;
    bit  seen;
    pulse_start();
    c0 = cyc;
    hb_from = c0 + 1 + START_OFF;
    hb_len  = hold;
    @(negedge clk); start = 0;
    chk({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_busy_on"}, busy, 1'b1);
    chk({tag, "_xrst_low"}, rf_xreset_n, 1'b0);
    seen = 0;
    // Extra start pulses land in WAIT_RDY (cycle c0+23) and in the first GAP (c0+39).
    for (int k = 2; k < 400 && !seen; k++) begin
      start = inject && (k == 24 || k == 40);
      @(negedge clk);
      seen = done;
    end
    start = 0;
    @(negedge clk);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_busy_off"}, busy, 1'b0);
    chk({tag, "_xrst_high"}, rf_xreset_n, 1'b1);
    chk({tag, "_cmd_count"}, cmd_count, N_CMD);
    chk({tag, "_n_starts"}, n_starts, N_CMD);
    chk({tag, "_xrst_low_clks"}, low_cnt, RST_C);
    chk({tag, "_first_start"}, first_start - busy_rise, START_OFF + hold);
    chk({tag, "_done_time"}, done_rise - busy_rise, DONE_OFF + hold);
    chk({tag, "_queue_left"}, exp_q.size(), 0);
    hb_len = 0;
  endtask

  initial begin
    #2 reset = 1;
    repeat (3) @(negedge clk);
    chk("rst_xreset_n", rf_xreset_n, 1'b0);
    chk("rst_spi_start", spi_start, 1'b0);
    chk("rst_spi_word", spi_word, 24'h0);
    chk("rst_rom_addr", rom_addr, 9'h0);
    chk("rst_cmd_count", cmd_count, 9'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    reset = 0;
    repeat (5) @(negedge clk);
    chk("idle_xreset_n", rf_xreset_n, 1'b0);

    run_seq("base", 0, 0);
    run_seq("rerun", 0, 0);
    run_seq("ignore", 1, 0);
    run_seq("stall", 0, 7);

    // Reset in the middle of command 1's SPI wait.
    pulse_start();
    @(negedge clk); start = 0;
    for (int k = 0; k < 300 && n_starts < 2; k++) @(negedge clk);
    chk("mid_reach_cmd1", n_starts, 2);
    repeat (3) @(negedge clk);
    reset = 1;
    #1;
    chk("mid_xreset_n", rf_xreset_n, 1'b0);
    chk("mid_spi_start", spi_start, 1'b0);
    chk("mid_spi_word", spi_word, 24'h0);
    chk("mid_rom_addr", rom_addr, 9'h0);
    chk("mid_cmd_count", cmd_count, 9'h0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_err", err, 1'b0);
    @(negedge clk); reset = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    run_seq("after_rst", 0, 0);

    // Slave never answers command 2. done is accepted for TO_C clocks after the
    // pulse; err appears on the clock after that window.
    drop_idx = 2;
    pulse_start();
    @(negedge clk); start = 0;
    for (int k = 0; k < 400 && !err; k++) @(negedge clk);
    @(negedge clk);
    chk("to_err", err, 1'b1);
    chk("to_err_time", err_rise - last_start, TO_C + 1);
    chk("to_cmd_count", cmd_count, 9'd2);
    chk("to_busy", busy, 1'b0);
    chk("to_done", done, 1'b0);
    chk("to_xreset_n", rf_xreset_n, 1'b1);
    chk("to_n_starts", n_starts, 3);
    exp_q.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_config_sequencer.md
RF_CONFIG_SEQUENCER -- requirements
Module: rf_config_sequencer

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2000: clocks rf_xreset_n is held low.
REQ-002 SHALL have parameter READY_WAIT, default 200: clocks waited after rf_xreset_n rises.
REQ-003 SHALL have parameter NUM_CMDS, default 368: entries in command ROM.
REQ-004 SHALL have parameter GAP_CYCLES, default 4: idle clocks between SPI transactions.
REQ-005 SHALL have parameter TIMEOUT, default 1024: max clocks from spi_start to spi_done.
REQ-006 clk  input  1  system clock, all logic on rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  one-cycle request to run the full init sequence.
REQ-009 rom_addr  output  9  command ROM index.
REQ-010 rom_data  input  24  ROM word {addr[15:0], data[7:0]}, valid 1 clock after rom_addr.
REQ-011 spi_start  output  1  one-cycle pulse launching an SPI write.
REQ-012 spi_word  output  24  command word for SPI master, stable from spi_start until spi_done.
REQ-013 spi_busy  input  1  SPI master transaction in progress.
REQ-014 spi_done  input  1  one-cycle pulse, SPI transaction complete.
REQ-015 rf_xreset_n  output  1  active-low reset to RF chip.
REQ-016 busy  output  1  sequence in progress.
REQ-017 done  output  1  sticky, all NUM_CMDS written.
REQ-018 err  output  1  sticky, SPI timeout occurred.
REQ-019 cmd_count  output  9  commands completed in current run.

Function
REQ-020 States SHALL be IDLE, HOLD_RST, WAIT_RDY, FETCH, LOAD, ISSUE, WAIT_SPI, GAP, FINISH, ERROR.
REQ-021 IDLE/FINISH/ERROR + start -> HOLD_RST next clock; clears done, err, cmd_count, rom_addr.
REQ-022 start in any other state SHALL be ignored.
REQ-023 HOLD_RST: rf_xreset_n=0 for exactly RESET_CYCLES clocks, then -> WAIT_RDY with rf_xreset_n=1.
REQ-024 WAIT_RDY: exactly READY_WAIT clocks, then -> FETCH.
REQ-025 FETCH: rom_addr=cmd_count held; -> LOAD next clock.
REQ-026 LOAD: spi_word <= rom_data; -> ISSUE.
REQ-027 ISSUE: if spi_busy=0, spi_start=1 for one clock, timeout counter cleared, -> WAIT_SPI; else stay in ISSUE with spi_start=0.
REQ-028 WAIT_SPI: spi_done=1 -> cmd_count+1, -> GAP; counter reaching TIMEOUT without spi_done -> ERROR.
REQ-029 spi_done outside WAIT_SPI SHALL be ignored.
REQ-030 GAP: GAP_CYCLES clocks; then cmd_count==NUM_CMDS -> FINISH, else -> FETCH; GAP_CYCLES=0 skips GAP.
REQ-031 FINISH: done=1, busy=0, rf_xreset_n=1.
REQ-032 ERROR: err=1, busy=0, rf_xreset_n=1, cmd_count frozen at failing index.
REQ-033 busy SHALL be 1 in every state except IDLE, FINISH, ERROR.
REQ-034 spi_start SHALL never be asserted two consecutive clocks nor outside ISSUE.
REQ-035 Counters SHALL be sized for parameter values; no wrap within a state.

Reset
REQ-036 reset SHALL force IDLE asynchronously, mid-operation included.
REQ-037 Reset values: rf_xreset_n=0, spi_start=0, spi_word=0, rom_addr=0, cmd_count=0, busy=0, done=0, err=0.
REQ-038 rf_xreset_n SHALL stay 0 in IDLE after reset until first start.

Verification
REQ-039 RESET_CYCLES=20, READY_WAIT=5, NUM_CMDS=4, GAP_CYCLES=2, SPI model done 10 clocks after start; pulse start -> rf_xreset_n low 20 clocks, high 5 clocks before first spi_start, 4 spi_start pulses with spi_word = ROM[0..3], done=1, cmd_count=4.
REQ-040 spi_busy held 1 for 7 clocks when ISSUE entered -> spi_start delayed 7 clocks, word unchanged.
REQ-041 TIMEOUT=16, model never returns spi_done on command 2 -> err=1 at 16 clocks after spi_start, cmd_count=2, busy=0.
REQ-042 reset asserted during WAIT_SPI of command 1 -> all outputs at REQ-037 values same cycle; new start reruns from rf_xreset_n low, ROM index 0.
REQ-043 start pulsed during WAIT_RDY and GAP -> ignored, sequence timing identical to REQ-039.
REQ-044 start after FINISH -> done cleared next clock, full sequence repeats identically.
